// File: rtl/led_defs_pkg.sv
// Shared LED-output definitions: FSM state encodings and default blink timing
// (50 ms at 100 MHz, matching the debouncer timing constants).
package led_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } led_state_t;

    localparam int LED_ON_CYCLES_DFLT  = 5000000;
    localparam int LED_OFF_CYCLES_DFLT = 5000000;
    localparam int LED_CNT_W_DFLT      = 23;
    localparam int LED_PEND_W_DFLT     = 4;

endpackage

// File: rtl/led_phase_cnt.sv
// Phase counter for led_blink_out: clearable, enabled up-counter that flags
// when it has reached a run-time terminal value.
module led_phase_cnt #(
    parameter int CNT_W = 23
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: clear wins over enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == limit);

endmodule

// File: rtl/led_blink_out.sv
// Event-to-LED blinker with a saturating pending queue.
// Define LED_OVF_EN to build the sticky o_ovf flag; otherwise o_ovf is tied low.
module led_blink_out
    import led_defs::*;
#(
    parameter int ON_CYCLES  = LED_ON_CYCLES_DFLT,
    parameter int OFF_CYCLES = LED_OFF_CYCLES_DFLT,
    parameter int CNT_W      = LED_CNT_W_DFLT,
    parameter int PEND_W     = LED_PEND_W_DFLT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_evt,
    input  logic              i_clr,
    output logic              o_led,
    output logic              o_busy,
    output logic [PEND_W-1:0] o_pend,
    output logic              o_ovf
);

    localparam logic [CNT_W-1:0]  ON_LIM   = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LIM  = CNT_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1'b1);

    led_state_t        state_r;
    led_state_t        state_nxt_s;
    logic [PEND_W-1:0] pend_r;
    logic [PEND_W-1:0] pend_nxt_s;
    logic              led_r;
    logic              busy_r;
    logic [CNT_W-1:0]  limit_s;
    logic              cnt_clr_s;
    logic              cnt_en_s;
    logic              cnt_tc_s;
    logic              take_s;
    logic              direct_s;
    logic              add_s;
    logic              full_s;
    logic              pend_nz_s;

    assign pend_nz_s = (pend_r != {PEND_W{1'b0}});

    led_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clr     (cnt_clr_s),
        .en      (cnt_en_s),
        .limit   (limit_s),
        .tc      (cnt_tc_s)
    );

    // Next-state logic; the counter is held clear except while a phase runs.
    always_comb begin
        state_nxt_s = state_r;
        take_s      = 1'b0;
        direct_s    = 1'b0;
        cnt_clr_s   = 1'b1;
        cnt_en_s    = 1'b0;
        limit_s     = ON_LIM;
        if (i_clr) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pend_nz_s) begin
                        state_nxt_s = ST_ON;
                        take_s      = 1'b1;
                    end else if (i_evt) begin
                        state_nxt_s = ST_ON;
                        direct_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ON: begin
                    limit_s = ON_LIM;
                    if (cnt_tc_s) begin
                        state_nxt_s = ST_OFF;
                    end else begin
                        cnt_clr_s = 1'b0;
                        cnt_en_s  = 1'b1;
                    end
                end
                ST_OFF: begin
                    limit_s = OFF_LIM;
                    if (cnt_tc_s) begin
                        if (pend_nz_s) begin
                            state_nxt_s = ST_ON;
                            take_s      = 1'b1;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        cnt_clr_s = 1'b0;
                        cnt_en_s  = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    assign add_s  = i_evt & ~direct_s;
    assign full_s = (pend_r == PEND_MAX);

    // Pending-queue update; an add and a take in the same cycle cancel out.
    always_comb begin
        pend_nxt_s = pend_r;
        if (i_clr) begin
            pend_nxt_s = {PEND_W{1'b0}};
        end else if (add_s && !take_s) begin
            if (full_s) begin
                pend_nxt_s = pend_r;
            end else begin
                pend_nxt_s = pend_r + PEND_ONE;
            end
        end else if (take_s && !add_s) begin
            pend_nxt_s = pend_r - PEND_ONE;
        end else begin
            pend_nxt_s = pend_r;
        end
    end

    // State, queue and output flops; LED/busy are decoded from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            pend_r  <= {PEND_W{1'b0}};
            led_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pend_r  <= pend_nxt_s;
            led_r   <= (state_nxt_s == ST_ON);
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

`ifdef LED_OVF_EN
    logic ovf_r;
    logic drop_s;

    assign drop_s = add_s & ~take_s & full_s & ~i_clr;

    // Sticky overflow flag, cleared only by reset or i_clr.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_r <= 1'b0;
        end else if (i_clr) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | drop_s;
        end
    end

    assign o_ovf = ovf_r;
`else
    assign o_ovf = 1'b0;
`endif

    assign o_led  = led_r;
    assign o_busy = busy_r;
    assign o_pend = pend_r;

endmodule

// File: tb/tb_led_blink_out.sv
// Self-checking bench for led_blink_out: a timeline model of blink windows
// checked every cycle, plus hand-computed expectations per scenario.
module tb_led_blink_out;

    localparam int ON     = 4;
    localparam int OFF    = 3;
    localparam int CNT_W  = 3;
    localparam int PEND_W = 2;
    localparam int PMAX   = (1 << PEND_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              evt;
    logic              clr;
    logic              o_led;
    logic              o_busy;
    logic [PEND_W-1:0] o_pend;
    logic              o_ovf;

    led_blink_out #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .CNT_W      (CNT_W),
        .PEND_W     (PEND_W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_evt   (evt),
        .i_clr   (clr),
        .o_led   (o_led),
        .o_busy  (o_busy),
        .o_pend  (o_pend),
        .o_ovf   (o_ovf)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: start cycle of the current/last blink, queue depth, sticky flag.
    int m_cur  = -1;
    int m_pend = 0;
    bit m_ovf  = 1'b0;

    bit exp_valid = 1'b0;
    bit exp_led, exp_busy, exp_ovf;
    int exp_pend;

    // Per-scenario statistics gathered by the compare process.
    int   rises[$];
    int   led_hi   = 0;
    int   busy_hi  = 0;
    int   max_pend = 0;
    logic prev_led = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rise_at(input int i);
        return (rises.size() > i) ? rises[i] : -1;
    endfunction

    task automatic model_reset();
        m_cur  = -1;
        m_pend = 0;
        m_ovf  = 1'b0;
    endtask

    // Advance the model with the inputs applied during cycle t.
    task automatic model_step(input int t, input bit e, input bit c);
        bit idle, take, direct, add;
        if (c) begin
            model_reset();
            return;
        end
        idle   = (m_cur < 0) || (t >= m_cur + ON + OFF);
        take   = 1'b0;
        direct = 1'b0;
        if (idle) begin
            if (m_pend > 0) begin
                take = 1'b1; m_cur = t + 1;
            end else if (e) begin
                direct = 1'b1; m_cur = t + 1;
            end
        end else if (t == m_cur + ON + OFF - 1 && m_pend > 0) begin
            take = 1'b1; m_cur = t + 1;
        end
        add = e && !direct;
        if (add && !take) begin
            if (m_pend == PMAX) begin
`ifdef LED_OVF_EN
                m_ovf = 1'b1;
`endif
            end else begin
                m_pend++;
            end
        end else if (take && !add) begin
            m_pend--;
        end
    endtask

    // One clock: publish expectations for this cycle, then drive its inputs.
    task automatic tick(input bit e, input bit c);
        @(posedge clk);
        #1;
        cyc++;
        exp_led   = (m_cur >= 0) && (cyc >= m_cur) && (cyc < m_cur + ON);
        exp_busy  = (m_cur >= 0) && (cyc >= m_cur) && (cyc < m_cur + ON + OFF);
        exp_pend  = m_pend;
        exp_ovf   = m_ovf;
        exp_valid = 1'b1;
        evt = e;
        clr = c;
        model_step(cyc, e, c);
    endtask

    task automatic idle_n(input int n);
        repeat (n) tick(1'b0, 1'b0);
    endtask

    task automatic clear_stats();
        rises.delete();
        led_hi   = 0;
        busy_hi  = 0;
        max_pend = 0;
    endtask

    // Compare process: DUT against model on every checked cycle.
    always @(negedge clk) begin
        if (exp_valid) begin
            check("led",  {31'd0, o_led},  {31'd0, exp_led});
            check("busy", {31'd0, o_busy}, {31'd0, exp_busy});
            check("pend", {30'd0, o_pend}, exp_pend);
            check("ovf",  {31'd0, o_ovf},  {31'd0, exp_ovf});
            if (o_led === 1'b1 && prev_led !== 1'b1) rises.push_back(cyc);
            if (o_led === 1'b1) led_hi++;
            if (o_busy === 1'b1) busy_hi++;
            if (int'(o_pend) > max_pend) max_pend = int'(o_pend);
        end
        prev_led <= o_led;
    end

    int t0;

    initial begin
        clk = 1'b0; rst_n = 1'b0; evt = 1'b0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_led",  {31'd0, o_led},  32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_pend", {30'd0, o_pend}, 32'd0);
        check("rst_ovf",  {31'd0, o_ovf},  32'd0);
        rst_n = 1'b1;
        idle_n(3);

        // Single event.
        clear_stats();
        tick(1'b1, 1'b0); t0 = cyc;
        idle_n(15);
        check("s1_nrise", rises.size(), 32'd1);
        check("s1_rise0", rise_at(0), t0 + 1);
        check("s1_ledhi", led_hi, 32'd4);
        check("s1_busyhi", busy_hi, 32'd7);

        // Three consecutive events.
        clear_stats();
        tick(1'b1, 1'b0); t0 = cyc;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        idle_n(30);
        check("s2_nrise", rises.size(), 32'd3);
        check("s2_rise0", rise_at(0), t0 + 1);
        check("s2_rise1", rise_at(1), t0 + 8);
        check("s2_rise2", rise_at(2), t0 + 15);
        check("s2_maxpend", max_pend, 32'd2);
        check("s2_ledhi", led_hi, 32'd12);

        // Queue saturation.
        clear_stats();
        tick(1'b1, 1'b0);
        repeat (5) tick(1'b1, 1'b0);
        idle_n(35);
        check("s3_nrise", rises.size(), 32'd4);
        check("s3_maxpend", max_pend, 32'd3);
`ifdef LED_OVF_EN
        check("s3_ovf", {31'd0, o_ovf}, 32'd1);
`else
        check("s3_ovf", {31'd0, o_ovf}, 32'd0);
`endif
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check("s3_ovf_clr", {31'd0, o_ovf}, 32'd0);
        idle_n(3);

        // Event on the OFF->ON edge while one entry is pending.
        clear_stats();
        tick(1'b1, 1'b0); t0 = cyc;
        tick(1'b1, 1'b0);
        idle_n(5);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("s4_pend_hold", {30'd0, o_pend}, 32'd1);
        idle_n(25);
        check("s4_nrise", rises.size(), 32'd3);
        check("s4_rise1", rise_at(1), t0 + 8);
        check("s4_rise2", rise_at(2), t0 + 15);

        // Clear mid-ON with two pending and a simultaneous event.
        clear_stats();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        check("s5_pend_pre", {30'd0, o_pend}, 32'd2);
        tick(1'b0, 1'b0);
        check("s5_led", {31'd0, o_led}, 32'd0);
        check("s5_pend", {30'd0, o_pend}, 32'd0);
        check("s5_busy", {31'd0, o_busy}, 32'd0);
        idle_n(15);
        check("s5_nrise", rises.size(), 32'd1);

        // Asynchronous reset mid-ON, then a normal blink.
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("s6_led_pre", {31'd0, o_led}, 32'd1);
        exp_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_led_async", {31'd0, o_led}, 32'd0);
        check("s6_busy_async", {31'd0, o_busy}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_stats();
        tick(1'b1, 1'b0); t0 = cyc;
        idle_n(12);
        check("s6_nrise", rises.size(), 32'd1);
        check("s6_rise0", rise_at(0), t0 + 1);
        check("s6_ledhi", led_hi, 32'd4);

        exp_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
